ram_arbiter_16bit: RTL and testbench
====================================

Name: ram_arbiter_16bit

Overview:
- Shares the single-port program/data RAM of the 16-bit RISC CPU between three requesters:
  - instruction fetch (IF)
  - load/store unit (LS)
  - external program loader (LD)
- Sequences every access (issue, read-latency wait, acknowledge) with a small FSM.
- Returns one-cycle acks so the controller can hold timer_E until its memory step completes.

Parameters:
- ADDR_W, 8, RAM address width.
- DATA_W, 16, RAM data width.
- RD_LAT, 1, RAM read latency in cycles after ram_en is sampled; legal 1..3.

Ports:
- CLK  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; read only.
- if_addr  in  ADDR_W  fetch address.
- ls_req  in  1  load/store request.
- ls_we  in  1  1 = store, 0 = load.
- ls_addr  in  ADDR_W  load/store address.
- ls_wdata  in  DATA_W  store data.
- ld_req  in  1  loader request.
- ld_we  in  1  1 = write, 0 = read-back.
- ld_addr  in  ADDR_W  loader address.
- ld_wdata  in  DATA_W  loader write data.
- if_ack  out  1  one-cycle completion pulse to IF.
- ls_ack  out  1  one-cycle completion pulse to LS.
- ld_ack  out  1  one-cycle completion pulse to LD.
- rdata  out  DATA_W  read data; valid only while an ack is high for a read.
- ram_en  out  1  RAM access strobe.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data.
- busy  out  1  high whenever state != IDLE.
- gnt_id  out  2  current owner: 0 = none, 1 = IF, 2 = LS, 3 = LD.

Behaviour:
- Reset: while rst is high, regardless of state:
  - state = IDLE.
  - All outputs = 0: acks, ram_en, ram_we, ram_addr, ram_wdata, rdata, busy, gnt_id.
  - rr_ptr = 0.
  - Any in-flight transaction is dropped; no ack is issued for it.
- Handshake:
  - A requester raises req with operands stable and holds them until its ack.
  - It must drop req in the cycle after the ack; req still high in IDLE is a new request.
  - Operands are latched at grant, so a req dropped early is a protocol violation: the transaction still completes and the ack still pulses.
- Arbitration (IDLE only, on a rising edge):
  - LD has fixed highest priority.
  - IF vs LS is round-robin on rr_ptr:
    - rr_ptr = 0: LS wins a tie.
    - rr_ptr = 1: IF wins a tie.
  - rr_ptr updates only on an IF/LS grant: set to 1 after LS is granted, 0 after IF.
  - An LD grant leaves rr_ptr unchanged.
- IF accesses are always reads; the IF we is forced to 0.
- FSM states: IDLE, ISSUE, WAIT, ACK.
  - IDLE: if any req is high, latch winner id/we/addr/wdata into registers, go to ISSUE; else stay.
  - ISSUE, exactly 1 cycle:
    - ram_en = 1; ram_we/ram_addr/ram_wdata driven from the latched registers.
    - Next state: ACK for a write; WAIT with cnt = RD_LAT for a read.
  - WAIT:
    - ram_en = 0; cnt decrements each cycle.
    - When cnt == 1, capture ram_rdata into rdata at the edge and go to ACK.
  - ACK, exactly 1 cycle:
    - The owner's ack = 1; rdata holds the captured value (unchanged for writes).
    - Next state is IDLE unconditionally.
- Outputs are registered; gnt_id holds the owner id from ISSUE through ACK.
- Latency (cycle 0 = the cycle req is sampled high in IDLE):
  - Write: ram_en in cycle 1, ack in cycle 2.
  - Read: ram_en in cycle 1, ack in cycle 2 + RD_LAT.
- Throughput:
  - One mandatory IDLE cycle between transactions.
  - Back-to-back writes: 3 cycles each. Reads: 3 + RD_LAT cycles each.
- Simultaneous events:
  - A new request during ISSUE/WAIT/ACK is not sampled.
  - It waits (req held) and is arbitrated in the next IDLE.
- Exactly one ack may be high in any cycle; acks never overlap ram_en.

Test Plan:
- Reset mid-read (RD_LAT = 2): assert rst during WAIT → all outputs 0 immediately; no ack follows; state IDLE after rst drops.
- LS store alone: ls_req = 1, ls_we = 1, addr 0x12, data 0xBEEF → ram_en/ram_we high in cycle 1 with addr 0x12, data 0xBEEF; ls_ack in cycle 2; busy high cycles 1–2.
- IF read, RD_LAT = 1: RAM model returns 0x1234 at addr 0x05 → if_ack in cycle 3 with rdata = 0x1234. Repeat with RD_LAT = 3 → if_ack in cycle 5.
- Round-robin: IF and LS both held high from reset → grants LS, IF, LS, IF (gnt_id 2, 1, 2, 1); acks never overlap.
- LD priority: all three req high → LD served first (gnt_id 3); then LS, then IF; rr_ptr unaffected by the LD grant.
- Early req drop: ls_req dropped during WAIT → ls_ack still pulses once with the correct read data; no second transaction starts.

Source files
------------

// File: rtl/ram_arbiter_16bit_if.sv
// ram_arbiter_16bit_if: requester, RAM and status signals shared by the arbiter and its clients.
interface ram_arbiter_16bit_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic if_req, ls_req, ls_we, ld_req, ld_we;
  logic [ADDR_W-1:0] if_addr, ls_addr, ld_addr, ram_addr;
  logic [DATA_W-1:0] ls_wdata, ld_wdata, rdata, ram_wdata, ram_rdata;
  logic if_ack, ls_ack, ld_ack, ram_en, ram_we, busy;
  logic [1:0] gnt_id;
  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ld_req, ld_we, ld_addr, ld_wdata, ram_rdata,
    output if_ack, ls_ack, ld_ack, rdata, ram_en, ram_we, ram_addr, ram_wdata, busy, gnt_id
  );
  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ld_req, ld_we, ld_addr, ld_wdata, ram_rdata,
    input  if_ack, ls_ack, ld_ack, rdata, ram_en, ram_we, ram_addr, ram_wdata, busy, gnt_id
  );
endinterface

// File: rtl/ram_arbiter_16bit.sv
// ram_arbiter_16bit: shares one single-port RAM between fetch, load/store and loader with a 4-state access FSM.
module ram_arbiter_16bit #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input logic CLK,
  input logic rst,
  ram_arbiter_16bit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;
  state_t state, state_n;
  logic [1:0] win, cnt;
  logic we_q, rr_ptr, sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  // LD always wins; IF takes a tie only when rr_ptr points at it
  always_comb begin
    win = bus.ld_req ? 2'd3 : (bus.if_req && (!bus.ls_req || rr_ptr)) ? 2'd1 : bus.ls_req ? 2'd2 : 2'd0;
    sel_we = win == 2'd3 ? bus.ld_we : win == 2'd2 ? bus.ls_we : 1'b0;
    sel_addr = win == 2'd3 ? bus.ld_addr : win == 2'd2 ? bus.ls_addr : bus.if_addr;
    sel_wdata = win == 2'd3 ? bus.ld_wdata : win == 2'd2 ? bus.ls_wdata : '0;
    state_n = state == IDLE ? (win != 2'd0 ? ISSUE : IDLE) :
              state == ISSUE ? (we_q ? ACK : WAIT) :
              state == WAIT ? (cnt == 2'd1 ? ACK : WAIT) : IDLE;
  end
  // Outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      we_q <= 1'b0;
      rr_ptr <= 1'b0;
      bus.if_ack <= 1'b0;
      bus.ls_ack <= 1'b0;
      bus.ld_ack <= 1'b0;
      bus.rdata <= '0;
      bus.ram_en <= 1'b0;
      bus.ram_we <= 1'b0;
      bus.ram_addr <= '0;
      bus.ram_wdata <= '0;
      bus.busy <= 1'b0;
      bus.gnt_id <= 2'd0;
    end else begin
      state <= state_n;
      cnt <= state == ISSUE ? 2'(RD_LAT) : cnt - 2'd1;
      bus.ram_en <= state_n == ISSUE;
      bus.ram_we <= state_n == ISSUE && sel_we;
      bus.busy <= state_n != IDLE;
      bus.gnt_id <= state_n == IDLE ? 2'd0 : state == IDLE ? win : bus.gnt_id;
      bus.if_ack <= state_n == ACK && bus.gnt_id == 2'd1;
      bus.ls_ack <= state_n == ACK && bus.gnt_id == 2'd2;
      bus.ld_ack <= state_n == ACK && bus.gnt_id == 2'd3;
      if (state == IDLE && win != 2'd0) begin
        we_q <= sel_we;
        bus.ram_addr <= sel_addr;
        bus.ram_wdata <= sel_wdata;
        rr_ptr <= win == 2'd3 ? rr_ptr : win == 2'd2;
      end
      if (state == WAIT && cnt == 2'd1) bus.rdata <= bus.ram_rdata;
    end
  end
endmodule

// File: tb/tb_ram_arbiter_16bit.sv
// tb_ram_arbiter_16bit: directed checks of the RAM arbiter at read latencies 1, 2 and 3.
module tb_ram_arbiter_16bit;
  logic clk = 1'b0;
  logic rst1 = 1'b1, rst2 = 1'b1, rst3 = 1'b1;
  always #5 clk = ~clk;
  ram_arbiter_16bit_if a1(), a2(), a3();
  ram_arbiter_16bit #(.RD_LAT(1)) d1 (.CLK(clk), .rst(rst1), .bus(a1.slave));
  ram_arbiter_16bit #(.RD_LAT(2)) d2 (.CLK(clk), .rst(rst2), .bus(a2.slave));
  ram_arbiter_16bit #(.RD_LAT(3)) d3 (.CLK(clk), .rst(rst3), .bus(a3.slave));
  logic [15:0] mem [256];
  logic [7:0] q1, q2, q3;
  always @(posedge clk) begin
    if (a1.ram_en) q1 <= a1.ram_addr;
    if (a2.ram_en) q2 <= a2.ram_addr;
    if (a3.ram_en) q3 <= a3.ram_addr;
  end
  assign a1.ram_rdata = mem[q1];
  assign a2.ram_rdata = mem[q2];
  assign a3.ram_rdata = mem[q3];
  int n_cmp = 0, n_bad = 0, viol;
  logic [1:0] gs [4];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic collect(input int n, input bit drop);
    int k;
    k = 0;
    viol = 0;
    gs = '{default: 2'd0};
    for (int c = 0; c < 80 && k < n; c++) begin
      step();
      if ($countones({a1.if_ack, a1.ls_ack, a1.ld_ack}) > 1) viol++;
      if ((a1.if_ack | a1.ls_ack | a1.ld_ack) && a1.ram_en) viol++;
      if (a1.if_ack | a1.ls_ack | a1.ld_ack) begin
        gs[k] = a1.ld_ack ? 2'd3 : a1.ls_ack ? 2'd2 : 2'd1;
        if (a1.gnt_id != gs[k]) viol++;
        k++;
        if (drop) begin
          if (a1.if_ack) a1.if_req = 1'b0;
          if (a1.ls_ack) a1.ls_req = 1'b0;
          if (a1.ld_ack) a1.ld_req = 1'b0;
        end
      end
    end
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'hA000 + 16'(i);
    mem[5] = 16'h1234;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: timeout");
    $fatal(1);
  end
  initial begin
    fork
      begin
        {a1.if_req, a1.ls_req, a1.ls_we, a1.ld_req, a1.ld_we} = '0;
        {a1.if_addr, a1.ls_addr, a1.ld_addr, a1.ls_wdata, a1.ld_wdata} = '0;
        step();
        step();
        chk("rst_ctl", {a1.busy, a1.gnt_id, a1.ram_en, a1.ram_we, a1.if_ack, a1.ls_ack, a1.ld_ack, a1.ram_addr}, 0);
        chk("rst_data", {a1.rdata, a1.ram_wdata}, 0);
        rst1 = 1'b0;
        a1.ls_req = 1'b1; a1.ls_we = 1'b1; a1.ls_addr = 8'h12; a1.ls_wdata = 16'hBEEF;
        step();
        chk("st_c1_bus", {a1.ram_en, a1.ram_we, a1.ram_addr, a1.ram_wdata}, {2'b11, 8'h12, 16'hBEEF});
        chk("st_c1_ctl", {a1.busy, a1.gnt_id, a1.ls_ack}, {1'b1, 2'd2, 1'b0});
        step();
        chk("st_c2", {a1.busy, a1.ls_ack, a1.ram_en, a1.if_ack, a1.ld_ack}, 5'b11000);
        a1.ls_req = 1'b0;
        step();
        chk("st_c3", {a1.busy, a1.gnt_id, a1.ls_ack}, 0);
        a1.if_req = 1'b1; a1.if_addr = 8'h05;
        step();
        chk("rd1_c1", {a1.ram_en, a1.ram_we, a1.ram_addr, a1.gnt_id}, {2'b10, 8'h05, 2'd1});
        step();
        chk("rd1_c2", {a1.ram_en, a1.if_ack, a1.busy}, 3'b001);
        step();
        chk("rd1_c3", {a1.if_ack, a1.rdata}, {1'b1, 16'h1234});
        a1.if_req = 1'b0;
        step();
        rst1 = 1'b1;
        step();
        rst1 = 1'b0;
        a1.if_req = 1'b1; a1.ls_req = 1'b1; a1.ls_we = 1'b1; a1.ls_addr = 8'h20;
        collect(4, 1'b0);
        a1.if_req = 1'b0; a1.ls_req = 1'b0;
        chk("rr_g0", gs[0], 2);
        chk("rr_g1", gs[1], 1);
        chk("rr_g2", gs[2], 2);
        chk("rr_g3", gs[3], 1);
        chk("rr_excl", viol, 0);
        step();
        a1.if_req = 1'b1; a1.ls_req = 1'b1; a1.ld_req = 1'b1; a1.ld_we = 1'b1; a1.ld_addr = 8'h30;
        collect(3, 1'b1);
        chk("ld_g0", gs[0], 3);
        chk("ld_g1", gs[1], 2);
        chk("ld_g2", gs[2], 1);
        chk("ld_excl", viol, 0);
        step();
        a1.ls_req = 1'b1; a1.ls_we = 1'b0; a1.ls_addr = 8'h07;
        step();
        step();
        a1.ls_req = 1'b0;
        chk("ed_c2", {a1.ls_ack, a1.busy}, 2'b01);
        step();
        chk("ed_c3", {a1.ls_ack, a1.rdata}, {1'b1, 16'hA007});
        viol = 0;
        for (int i = 0; i < 4; i++) begin
          step();
          if (a1.ram_en | a1.busy | a1.if_ack | a1.ls_ack | a1.ld_ack) viol++;
        end
        chk("ed_quiet", viol, 0);
      end
      begin
        int bad3;
        {a3.if_req, a3.ls_req, a3.ls_we, a3.ld_req, a3.ld_we} = '0;
        {a3.if_addr, a3.ls_addr, a3.ld_addr, a3.ls_wdata, a3.ld_wdata} = '0;
        step();
        step();
        rst3 = 1'b0;
        step();
        a3.if_req = 1'b1; a3.if_addr = 8'h05;
        step();
        chk("rd3_c1", {a3.ram_en, a3.ram_addr, a3.gnt_id}, {1'b1, 8'h05, 2'd1});
        bad3 = 0;
        for (int i = 0; i < 3; i++) begin
          step();
          if (a3.if_ack | a3.ram_en | !a3.busy) bad3++;
        end
        chk("rd3_wait", bad3, 0);
        step();
        chk("rd3_c5", {a3.if_ack, a3.rdata}, {1'b1, 16'h1234});
        a3.if_req = 1'b0;
        step();
        chk("rd3_done", {a3.if_ack, a3.busy}, 0);
      end
      begin
        int bad2;
        {a2.if_req, a2.ls_req, a2.ls_we, a2.ld_req, a2.ld_we} = '0;
        {a2.if_addr, a2.ls_addr, a2.ld_addr, a2.ls_wdata, a2.ld_wdata} = '0;
        step();
        step();
        rst2 = 1'b0;
        step();
        a2.if_req = 1'b1; a2.if_addr = 8'h05;
        step();
        step();
        chk("r2_wait", {a2.busy, a2.gnt_id, a2.ram_en}, {1'b1, 2'd1, 1'b0});
        #1;
        rst2 = 1'b1;
        a2.if_req = 1'b0;
        #1;
        chk("r2_rst_ctl", {a2.busy, a2.gnt_id, a2.ram_en, a2.ram_we, a2.if_ack, a2.ls_ack, a2.ld_ack, a2.ram_addr}, 0);
        chk("r2_rst_data", {a2.rdata, a2.ram_wdata}, 0);
        step();
        rst2 = 1'b0;
        bad2 = 0;
        for (int i = 0; i < 5; i++) begin
          step();
          if (a2.if_ack | a2.ls_ack | a2.ld_ack | a2.busy | a2.ram_en | (a2.gnt_id != 2'd0)) bad2++;
        end
        chk("r2_after", bad2, 0);
      end
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
